// File: rtl/xadac_rob.sv
// ---------------------------------------------------------------------------
// xadac_rob
//
// Reorder buffer in front of the xadac spill-register cut on the response
// path. Each issued accelerator request allocates one slot, in order. The
// responses come back tagged with their slot ID and may arrive in any order.
// They leave on the master port in allocation order.
//
// All master-side outputs come straight from registers. No slave input can
// reach mst_valid or mst_data through a combinational path.
//
// Parameters
//   Depth  number of slots (power of two, >= 2)
//   DataT  response payload type
//   IdW    slot ID width, derived from Depth
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   flush          synchronous clear of all slots and pointers
//   alloc_valid    request to allocate the next slot
//   alloc_ready    a slot is free
//   alloc_id       ID of the slot granted on an alloc handshake
//   rsp_valid      response present
//   rsp_ready      always 1
//   rsp_id         slot targeted by the response
//   rsp_data       response payload
//   rsp_err        response targeted a free or already-completed slot
//   mst_valid      head slot is complete
//   mst_data       payload of the head slot
//   mst_ready      downstream accepts the head slot
// ---------------------------------------------------------------------------
module xadac_rob #(
    parameter int unsigned Depth = 4,
    parameter type         DataT = logic,
    localparam int unsigned IdW  = $clog2(Depth)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           flush,
    input  logic           alloc_valid,
    output logic           alloc_ready,
    output logic [IdW-1:0] alloc_id,
    input  logic           rsp_valid,
    output logic           rsp_ready,
    input  logic [IdW-1:0] rsp_id,
    input  DataT           rsp_data,
    output logic           rsp_err,
    output logic           mst_valid,
    output DataT           mst_data,
    input  logic           mst_ready
);

    // Pointers carry one extra wrap bit, so full and empty stay distinct
    // even when the slot indices match.
    localparam int unsigned PtrW = IdW + 1;

    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [PtrW-1:0]  count;
    logic [IdW-1:0]   head_idx;
    logic [IdW-1:0]   tail_idx;
    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] done_q;
    DataT             data_q [Depth];

    logic full;
    logic alloc_fire;
    logic rsp_hit;
    logic rsp_ok;
    logic pop;

    assign head_idx = head_q[IdW-1:0];
    assign tail_idx = tail_q[IdW-1:0];
    assign count    = tail_q - head_q;
    assign full     = (count == PtrW'(Depth));

    // alloc_ready depends only on the registered count. A pop in the same
    // cycle as a full buffer does not open a slot until the next cycle.
    assign alloc_ready = !full;
    assign alloc_id    = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // A response is only meaningful for an allocated slot that is still
    // waiting. Anything else is dropped and flagged.
    assign rsp_ready = 1'b1;
    assign rsp_hit   = busy_q[rsp_id] && !done_q[rsp_id];
    assign rsp_ok    = rsp_valid && rsp_hit;
    assign rsp_err   = rsp_valid && !rsp_hit;

    assign mst_valid = busy_q[head_idx] && done_q[head_idx];
    assign mst_data  = data_q[head_idx];
    assign pop       = mst_valid && mst_ready;

    // Slot bookkeeping and pointers.
    //
    // An alloc, a response and a pop never touch the same slot bit in one
    // cycle, so applying them in sequence is safe:
    //   - alloc and pop share a slot only when the buffer is full, and alloc
    //     is blocked then;
    //   - a valid response needs a busy slot, so it cannot hit the slot being
    //     allocated;
    //   - a valid response needs !done, and a pop needs done.
    //
    // Flush takes priority over all three operations.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            if (alloc_fire) begin
                busy_q[tail_idx] <= 1'b1;
                done_q[tail_idx] <= 1'b0;
                tail_q           <= tail_q + PtrW'(1);
            end
            if (rsp_ok) begin
                done_q[rsp_id] <= 1'b1;
            end
            if (pop) begin
                busy_q[head_idx] <= 1'b0;
                done_q[head_idx] <= 1'b0;
                head_q           <= head_q + PtrW'(1);
            end
        end
    end

    // Payload storage. It is reset so that mst_data comes up as zero.
    // A flush leaves the payload storage untouched: once busy is cleared,
    // the old values are never presented with mst_valid set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Depth); i++) begin
                data_q[i] <= '0;
            end
        end else if (!flush && rsp_ok) begin
            data_q[rsp_id] <= rsp_data;
        end
    end

endmodule
